// File: rtl/obstacle_rect_v2_if.sv
// obstacle_rect_v2_if: control, geometry and collision-flag bundle between the game logic and the obstacle
interface obstacle_rect_v2_if #(parameter int W = 11);
    logic [1:0] mode;
    logic [3:0] btns;
    logic [W-1:0] obj_w, obj_h;
    logic [3:0] rect_color, player_color;
    logic passable;
    logic [W-1:0] player_h, player_v;
    logic [W-1:0] h_pos, v_pos;
    logic [3:0] rect_color_o;
    logic blk_up, blk_down, blk_left, blk_right, overlap, dir;
    modport master (
        output mode, btns, obj_w, obj_h, rect_color, player_color, passable, player_h, player_v,
        input h_pos, v_pos, rect_color_o, blk_up, blk_down, blk_left, blk_right, overlap, dir
    );
    modport slave (
        input mode, btns, obj_w, obj_h, rect_color, player_color, passable, player_h, player_v,
        output h_pos, v_pos, rect_color_o, blk_up, blk_down, blk_left, blk_right, overlap, dir
    );
endinterface

// File: rtl/obstacle_rect_v2.sv
// obstacle_rect_v2: movable maze obstacle with manual/auto-patrol motion and colour-aware collision flags
module obstacle_rect_v2 #(
    parameter int W = 11,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int PLAYER_SZ = 12,
    parameter int STEP = 1,
    parameter int AUTO_DIV = 4,
    parameter int H_INIT = 0,
    parameter int V_INIT = 0
) (
    input logic btnClk,
    input logic rst,
    obstacle_rect_v2_if.slave bus
);
    localparam int X = W + 1;
    localparam int CW = $clog2(AUTO_DIV + 1);
    localparam logic [W:0] ST = X'(STEP);
    localparam logic [W:0] LW = X'(SCREEN_W);
    localparam logic [W:0] LH = X'(SCREEN_H);
    localparam logic [W:0] PS = X'(PLAYER_SZ);
    localparam logic [CW-1:0] CMAX = CW'(AUTO_DIV - 1);
    typedef enum logic {FWD, REV} dir_e;
    logic [W-1:0] h_q, h_d, v_q, v_d, nxt;
    logic [W:0] he, ve, ow, oh, ph, pv, pa, sa, la;
    dir_e dir_q, dir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0] mode_q;
    logic xov, yov, blk, fit, tick;
    logic up_q, dn_q, lf_q, rt_q, ov_q;

    // One step along an axis; on the edge either wrap to the far side or clamp in place
    function automatic logic [W-1:0] step_pos(input logic [W:0] p, s, l, input logic inc, wrap);
        if (inc) return (p + s + ST <= l) ? W'(p + ST) : (wrap ? '0 : W'(l - s));
        return (p >= ST) ? W'(p - ST) : (wrap ? W'(l - s) : '0);
    endfunction

    assign he = {1'b0, h_q};
    assign ve = {1'b0, v_q};
    assign ow = {1'b0, bus.obj_w};
    assign oh = {1'b0, bus.obj_h};
    assign ph = {1'b0, bus.player_h};
    assign pv = {1'b0, bus.player_v};
    assign pa = bus.mode[0] ? ve : he;
    assign sa = bus.mode[0] ? oh : ow;
    assign la = bus.mode[0] ? LH : LW;
    assign fit = (dir_q == FWD) ? (pa + sa + ST <= la) : (pa >= ST);
    assign nxt = step_pos(pa, sa, la, dir_q == FWD, 1'b0);
    assign tick = cnt_q == CMAX;
    assign xov = ph < he + ow && ph + PS > he;
    assign yov = pv < ve + oh && pv + PS > ve;
    assign blk = bus.rect_color != bus.player_color && !bus.passable;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        dir_d = dir_q;
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (bus.mode != mode_q) begin
            cnt_d = '0;
            dir_d = FWD;
        end else if (!bus.mode[1]) begin
            h_d = bus.btns == 4'b0010 ? step_pos(he, ow, LW, 1'b1, !bus.mode[0]) :
                  bus.btns == 4'b0001 ? step_pos(he, ow, LW, 1'b0, !bus.mode[0]) : h_q;
            v_d = bus.btns == 4'b0100 ? step_pos(ve, oh, LH, 1'b1, !bus.mode[0]) :
                  bus.btns == 4'b1000 ? step_pos(ve, oh, LH, 1'b0, !bus.mode[0]) : v_q;
        end else if (tick) begin
            dir_d = fit ? dir_q : (dir_q == FWD ? REV : FWD);
            if (bus.mode[0]) v_d = nxt;
            else h_d = nxt;
        end
    end

    always_ff @(posedge btnClk or posedge rst) begin
        if (rst) begin
            h_q <= W'(H_INIT);
            v_q <= W'(V_INIT);
            dir_q <= FWD;
            cnt_q <= '0;
            mode_q <= '0;
            up_q <= 1'b0;
            dn_q <= 1'b0;
            lf_q <= 1'b0;
            rt_q <= 1'b0;
            ov_q <= 1'b0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
            dir_q <= dir_d;
            cnt_q <= cnt_d;
            mode_q <= bus.mode;
            up_q <= xov && pv == ve + oh && blk;
            dn_q <= xov && pv + PS == ve && blk;
            lf_q <= yov && ph == he + ow && blk;
            rt_q <= yov && ph + PS == he && blk;
            ov_q <= xov && yov;
        end
    end

    assign bus.h_pos = h_q;
    assign bus.v_pos = v_q;
    assign bus.dir = dir_q == REV;
    assign bus.rect_color_o = bus.rect_color;
    assign bus.blk_up = up_q;
    assign bus.blk_down = dn_q;
    assign bus.blk_left = lf_q;
    assign bus.blk_right = rt_q;
    assign bus.overlap = ov_q;
endmodule

// File: tb/tb_obstacle_rect_v2.sv
// tb_obstacle_rect_v2: directed tables, corner sequences and random traffic against a behavioural model
module tb_obstacle_rect_v2;
    localparam int SW = 640, SH = 480, PSZ = 12, STEP = 1, AD = 4, HI = 100, VI = 50;

    logic btnClk = 1'b0;
    logic rst = 1'b1;
    obstacle_rect_v2_if #(.W(11)) bus();

    obstacle_rect_v2 #(.W(11), .SCREEN_W(SW), .SCREEN_H(SH), .PLAYER_SZ(PSZ), .STEP(STEP),
                       .AUTO_DIV(AD), .H_INIT(HI), .V_INIT(VI)) dut (
        .btnClk(btnClk),
        .rst(rst),
        .bus(bus)
    );

    always #5 btnClk = ~btnClk;

    int checks = 0, failures = 0;
    int mh, mv, md, mc, mpm;
    bit e_up, e_dn, e_lf, e_rt, e_ov;

    typedef struct {
        int ph, pv, pc, pas;
        bit up, dn, lf, rt, ov;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", n, a, e, $time);
        end
    endtask

    task automatic model_reset();
        mh = HI; mv = VI; md = 0; mc = 0; mpm = 0;
        {e_up, e_dn, e_lf, e_rt, e_ov} = '0;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".h"}, int'(bus.h_pos), mh);
        chk({tag, ".v"}, int'(bus.v_pos), mv);
        chk({tag, ".dir"}, int'(bus.dir), md);
        chk({tag, ".up"}, int'(bus.blk_up), int'(e_up));
        chk({tag, ".down"}, int'(bus.blk_down), int'(e_dn));
        chk({tag, ".left"}, int'(bus.blk_left), int'(e_lf));
        chk({tag, ".right"}, int'(bus.blk_right), int'(e_rt));
        chk({tag, ".ovl"}, int'(bus.overlap), int'(e_ov));
        chk({tag, ".col"}, int'(bus.rect_color_o), int'(bus.rect_color));
    endtask

    // Bounce patrol on one axis, stepping in the current direction
    task automatic patrol(inout int p, input int s, input int lim);
        if (md == 0) begin
            if (p + s + STEP <= lim) p += STEP;
            else begin p = lim - s; md = 1; end
        end else begin
            if (p >= STEP) p -= STEP;
            else begin p = 0; md = 0; end
        end
    endtask

    task automatic tick(input string tag);
        int w, h, ph, pv, md_in, b;
        bit ne, x, y, wrap, ev;
        @(posedge btnClk);
        w = int'(bus.obj_w); h = int'(bus.obj_h);
        ph = int'(bus.player_h); pv = int'(bus.player_v);
        md_in = int'(bus.mode); b = int'(bus.btns);
        ne = bus.rect_color != bus.player_color && !bus.passable;
        x = ph < mh + w && ph + PSZ > mh;
        y = pv < mv + h && pv + PSZ > mv;
        e_ov = x && y;
        e_dn = x && pv + PSZ == mv && ne;
        e_up = x && pv == mv + h && ne;
        e_rt = y && ph + PSZ == mh && ne;
        e_lf = y && ph == mh + w && ne;
        ev = mc == AD - 1;
        wrap = md_in == 0;
        if (md_in != mpm) begin
            mc = 0; md = 0;
        end else begin
            mc = ev ? 0 : mc + 1;
            if (md_in < 2) begin
                case (b)
                    8: mv = mv >= STEP ? mv - STEP : (wrap ? SH - h : 0);
                    4: mv = mv + h + STEP <= SH ? mv + STEP : (wrap ? 0 : SH - h);
                    1: mh = mh >= STEP ? mh - STEP : (wrap ? SW - w : 0);
                    2: mh = mh + w + STEP <= SW ? mh + STEP : (wrap ? 0 : SW - w);
                    default: ;
                endcase
            end else if (ev) begin
                if (md_in == 2) patrol(mh, w, SW);
                else patrol(mv, h, SH);
            end
        end
        mpm = md_in;
        #1;
        chk_all(tag);
    endtask

    task automatic goto_pos(input int th, input int tv);
        int n = 0;
        bus.mode = 2'b01;
        while ((mh != th || mv != tv) && n < 3000) begin
            bus.btns = mh < th ? 4'd2 : mh > th ? 4'd1 : mv < tv ? 4'd4 : 4'd8;
            tick("goto");
            n++;
        end
        bus.btns = 4'd0;
        chk("goto_reached", int'(mh == th && mv == tv), 1);
    endtask

    initial begin
        int exp_h[6] = '{597, 598, 599, 600, 600, 599};
        int exp_d[6] = '{0, 0, 0, 0, 1, 1};
        int n;
        tbl[0] = '{110, 88, 5, 0, 0, 1, 0, 0, 0};
        tbl[1] = '{110, 88, 3, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{110, 88, 5, 1, 0, 0, 0, 0, 0};
        tbl[3] = '{140, 110, 5, 0, 0, 0, 1, 0, 0};
        tbl[4] = '{88, 110, 5, 0, 0, 0, 0, 1, 0};
        tbl[5] = '{110, 140, 5, 0, 1, 0, 0, 0, 0};
        tbl[6] = '{120, 120, 5, 0, 0, 0, 0, 0, 1};
        bus.mode = 2'b00; bus.btns = 4'd0; bus.obj_w = 11'd40; bus.obj_h = 11'd40;
        bus.rect_color = 4'd3; bus.player_color = 4'd5; bus.passable = 1'b0;
        bus.player_h = 11'd300; bus.player_v = 11'd300;
        model_reset();
        #22;
        chk("rst_h", int'(bus.h_pos), 100);
        chk("rst_v", int'(bus.v_pos), 50);
        chk_all("rst");
        rst = 1'b0;

        bus.btns = 4'd8;
        repeat (50) tick("wrapup");
        chk("wrap_zero", int'(bus.v_pos), 0);
        tick("wrapup");
        chk("wrap_far", int'(bus.v_pos), 440);

        goto_pos(598, 440);
        bus.btns = 4'd2;
        tick("clamp"); chk("clamp_599", int'(bus.h_pos), 599);
        tick("clamp"); chk("clamp_600", int'(bus.h_pos), 600);
        tick("clamp"); chk("clamp_hold", int'(bus.h_pos), 600);
        bus.btns = 4'd3;
        tick("notonehot"); chk("notonehot_hold", int'(bus.h_pos), 600);

        goto_pos(596, 440);
        bus.mode = 2'b10;
        tick("autoh_chg");
        for (int k = 0; k < 6; k++) begin
            repeat (3) begin
                tick("autoh_wait");
                chk("autoh_idle", int'(bus.h_pos), k == 0 ? 596 : exp_h[k-1]);
            end
            tick("autoh_move");
            chk("autoh_pos", int'(bus.h_pos), exp_h[k]);
            chk("autoh_dir", int'(bus.dir), exp_d[k]);
        end

        bus.mode = 2'b11; bus.obj_h = 11'd20;
        tick("autov_chg");
        chk("autov_dir0", int'(bus.dir), 0);
        repeat (3) begin
            tick("autov_wait");
            chk("autov_idle", int'(bus.v_pos), 440);
        end
        tick("autov_move");
        chk("autov_441", int'(bus.v_pos), 441);
        n = 0;
        while (md == 0 && n < 500) begin tick("autov_run"); n++; end
        chk("autov_bounced", int'(bus.dir), 1);
        tick("autov_run");

        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_h", int'(bus.h_pos), 100);
        chk("arst_v", int'(bus.v_pos), 50);
        chk_all("arst");
        @(negedge btnClk);
        rst = 1'b0;

        bus.obj_h = 11'd40;
        goto_pos(100, 100);
        for (int i = 0; i < 7; i++) begin
            bus.player_h = 11'(tbl[i].ph); bus.player_v = 11'(tbl[i].pv);
            bus.player_color = 4'(tbl[i].pc); bus.passable = tbl[i].pas[0];
            tick("coll");
            chk($sformatf("tbl%0d.up", i), int'(bus.blk_up), int'(tbl[i].up));
            chk($sformatf("tbl%0d.down", i), int'(bus.blk_down), int'(tbl[i].dn));
            chk($sformatf("tbl%0d.left", i), int'(bus.blk_left), int'(tbl[i].lf));
            chk($sformatf("tbl%0d.right", i), int'(bus.blk_right), int'(tbl[i].rt));
            chk($sformatf("tbl%0d.ovl", i), int'(bus.overlap), int'(tbl[i].ov));
        end

        for (int i = 0; i < 3000; i++) begin
            int ph, pv, sel;
            if ($urandom_range(0, 49) == 0) bus.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) bus.obj_w = 11'($urandom_range(1, SW));
            if ($urandom_range(0, 99) == 0) bus.obj_h = 11'($urandom_range(1, SH));
            bus.btns = $urandom_range(0, 1) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            bus.rect_color = 4'($urandom_range(0, 2));
            bus.player_color = 4'($urandom_range(0, 2));
            bus.passable = $urandom_range(0, 7) == 0;
            ph = mh - 20 + int'($urandom_range(0, int'(bus.obj_w) + 40));
            pv = mv - 20 + int'($urandom_range(0, int'(bus.obj_h) + 40));
            sel = $urandom_range(0, 5);
            if (sel == 0) ph = mh - PSZ;
            if (sel == 1) ph = mh + int'(bus.obj_w);
            if (sel == 2) pv = mv - PSZ;
            if (sel == 3) pv = mv + int'(bus.obj_h);
            bus.player_h = 11'(ph < 0 ? 0 : ph);
            bus.player_v = 11'(pv < 0 ? 0 : pv);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/obstacle_rect_v2.md
# obstacle_rect_v2

Parametrised movable obstacle for the VGA maze game, clocked by the button clock. It holds its own absolute position and moves it either from the player's buttons (wrap or clamp at the screen edges) or autonomously (bouncing patrol, horizontal or vertical). Each cycle it registers colour-aware collision flags against the player sprite for the player-movement controller. Its position and colour also feed the pixel generator.

## Interface
Parameters:
- `W`, 11: coordinate width, unsigned.
- `SCREEN_W`, 640: playfield width in pixels.
- `SCREEN_H`, 480: playfield height in pixels.
- `PLAYER_SZ`, 12: player sprite edge length (square).
- `STEP`, 1: pixels moved per move event.
- `AUTO_DIV`, 4: btnClk cycles per auto-mode move, ≥1.
- `H_INIT`, 0: horizontal position loaded on reset.
- `V_INIT`, 0: vertical position loaded on reset.

Ports:
- `btnClk`  in  1: clock. Reset `rst` is asynchronous, active-high; clock is `btnClk`.
- `rst`  in  1: async active-high reset.
- `mode`  in  2: 00 manual-wrap, 01 manual-clamp, 10 auto-horizontal, 11 auto-vertical.
- `btns`  in  4: {U,D,R,L}; only exact one-hot values 8/4/2/1 act.
- `obj_w`, `obj_h`  in  W: rectangle size; must satisfy 1 ≤ obj_w ≤ SCREEN_W and 1 ≤ obj_h ≤ SCREEN_H.
- `rect_color`, `player_color`  in  4: colours.
- `passable`  in  1: 1 forces all block flags to 0.
- `player_h`, `player_v`  in  W: player top-left corner.
- `h_pos`, `v_pos`  out  W: rectangle top-left corner (registered).
- `rect_color_o`  out  4: passthrough of rect_color.
- `blk_up`, `blk_down`, `blk_left`, `blk_right`  out  1: 1 = player move in that direction is blocked.
- `overlap`  out  1: player and rectangle interiors intersect.
- `dir`  out  1: auto FSM direction; 0 = FWD (+), 1 = REV (−).

## Operation
- Position update, manual modes, one-hot `btns` only; any other value holds the position.
  - U: if v_pos ≥ STEP, v_pos −= STEP; else wrap to SCREEN_H−obj_h, or clamp to 0.
  - D: if v_pos+obj_h+STEP ≤ SCREEN_H, v_pos += STEP; else wrap to 0, or clamp to SCREEN_H−obj_h.
  - L and R: same rules on h_pos, using SCREEN_W and obj_w.
- Auto modes ignore `btns`.
  - Tick counter counts 0..AUTO_DIV−1. A move event occurs on the cycle the counter reads AUTO_DIV−1; the counter then returns to 0.
  - FSM FWD: if pos+size+STEP ≤ limit, pos += STEP. Otherwise pos = limit−size and the state goes to REV (bounce; no overshoot).
  - FSM REV: if pos ≥ STEP, pos −= STEP. Otherwise pos = 0 and the state goes to FWD.
  - mode 10 moves h_pos only; mode 11 moves v_pos only. The other axis holds.
- Any change of `mode` (registered previous mode ≠ mode): counter := 0 and dir := FWD in that cycle, with no move that cycle.
- Collision terms, computed from the current (pre-update) h_pos/v_pos; ne = rect_color ≠ player_color.
  - xov = player_h < h_pos+obj_w && player_h+PLAYER_SZ > h_pos
  - yov = player_v < v_pos+obj_h && player_v+PLAYER_SZ > v_pos
  - blk_down = xov && player_v+PLAYER_SZ == v_pos && ne && !passable
  - blk_up = xov && player_v == v_pos+obj_h && ne && !passable
  - blk_right = yov && player_h+PLAYER_SZ == h_pos && ne && !passable
  - blk_left = yov && player_h == h_pos+obj_w && ne && !passable
  - overlap = xov && yov, regardless of colour and `passable`.
- Arithmetic: all sums and comparisons are evaluated at W+1 bits so no wrap-around occurs. Subtractions are only taken after the guarding compare.

## Timing
- Reset values: h_pos = H_INIT, v_pos = V_INIT, dir = 0, counter = 0, prev-mode = 00. All blk_* and overlap = 0. rect_color_o is combinational.
- All outputs except rect_color_o are registered on posedge btnClk.
- Position latency: 1 cycle from the sampled `btns`.
- Flags: 1-cycle latency. A flag computed at edge k uses the position before edge k's update, so it lags a rectangle move by 1 cycle.
- Auto mode: the first move happens AUTO_DIV cycles after reset release or a mode change.
- Reset asserted mid-motion clears everything immediately, without waiting for a clock edge.
- `obj_w`/`obj_h` changes take effect at the next move event; the bounce/clamp rules re-fit the rectangle.

## Test plan
- Reset with H_INIT=100, V_INIT=50: h_pos=100, v_pos=50, all flags 0. Then mode 00, btns=8 for 51 cycles: v_pos counts down to 0, then wraps to 480−obj_h (obj_h=40 → 440).
- Mode 01, obj_w=40, h_pos=598, btns=2 ×3: h_pos goes 599, 600, 600 (clamped). btns=3 (not one-hot): h_pos holds.
- Mode 10, AUTO_DIV=4, obj_w=40, start h_pos=596: a move every 4th cycle; h_pos goes 597, 598, 599, 600, then dir=1 and 599. Mode switch to 11 mid-run: dir=0 and the next move comes 4 cycles later, on v_pos.
- Rectangle at (100,100), 40×40, colours 3 vs 5, player at (110,88): blk_down=1. Set player_color=3: blk_down=0. Restore colours and set passable=1: blk_down=0.
- Player (140,110): blk_left=1. Player (88,110): blk_right=1. Player (110,140): blk_up=1. Player (120,120): overlap=1, no blk flags.
- Assert rst asynchronously between edges during an auto bounce: outputs return to reset values before the next edge.
